// File: rtl/sq_wave_pattern_sequencer.sv
// sq_wave_pattern_sequencer: steps a square-wave generator through a table of (on, off, reps) entries
module sq_wave_pattern_sequencer #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_wr,
  input  logic [AW-1:0] cfg_addr,
  input  logic [15:0]   cfg_wdata,
  input  logic [AW-1:0] last_idx,
  input  logic          loop,
  input  logic          start,
  input  logic          stop,
  input  logic          sq_wave_in,
  output logic [3:0]    ctrl_on,
  output logic [3:0]    ctrl_off,
  output logic          gen_rst,
  output logic          wave_en,
  output logic          busy,
  output logic [AW-1:0] cur_idx,
  output logic          done_tick
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [15:0] tbl [DEPTH];
  logic [15:0] ent;
  logic [7:0] rep_cnt, rep_cnt_nxt, reps_cur;
  logic [3:0] on_eff, off_eff;
  logic [7:0] reps_eff;
  logic [AW-1:0] last_eff, load_idx;
  logic load, gen_rst_nxt, done_nxt, sq_d, rise;
  if (DEPTH == 2**AW) begin : g_pow2
    assign last_eff = last_idx;
  end else begin : g_clip
    assign last_eff = (last_idx > AW'(DEPTH - 1)) ? AW'(DEPTH - 1) : last_idx;
  end
  // zero fields are clamped to 1 so the generator never sees an empty phase
  assign ent      = tbl[load_idx];
  assign on_eff   = (ent[3:0] == 4'd0) ? 4'd1 : ent[3:0];
  assign off_eff  = (ent[7:4] == 4'd0) ? 4'd1 : ent[7:4];
  assign reps_eff = (ent[15:8] == 8'd0) ? 8'd1 : ent[15:8];
  assign rise     = sq_wave_in & ~sq_d;
  always_comb begin
    state_nxt = state;
    load = 1'b0;
    load_idx = '0;
    rep_cnt_nxt = rep_cnt;
    gen_rst_nxt = 1'b0;
    done_nxt = 1'b0;
    if (state == IDLE) begin
      if (start && !stop) begin
        state_nxt = RUN;
        load = 1'b1;
        gen_rst_nxt = 1'b1;
      end
    end else if (stop) begin
      state_nxt = IDLE;
    end else if (rise) begin
      if (rep_cnt < reps_cur - 8'd1) begin
        rep_cnt_nxt = rep_cnt + 8'd1;
      end else if (cur_idx != last_eff) begin
        load = 1'b1;
        load_idx = cur_idx + 1'b1;
      end else if (loop) begin
        load = 1'b1;
      end else begin
        state_nxt = IDLE;
        done_nxt = 1'b1;
      end
    end
    if (load) rep_cnt_nxt = '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ctrl_on <= 4'd1;
      ctrl_off <= 4'd1;
      reps_cur <= 8'd1;
      gen_rst <= 1'b0;
      wave_en <= 1'b0;
      busy <= 1'b0;
      cur_idx <= '0;
      done_tick <= 1'b0;
      rep_cnt <= '0;
      sq_d <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tbl[i] <= 16'h0111;
    end else begin
      state <= state_nxt;
      busy <= state_nxt == RUN;
      wave_en <= state_nxt == RUN;
      ctrl_on <= load ? on_eff : ctrl_on;
      ctrl_off <= load ? off_eff : ctrl_off;
      reps_cur <= load ? reps_eff : reps_cur;
      cur_idx <= load ? load_idx : cur_idx;
      rep_cnt <= rep_cnt_nxt;
      gen_rst <= gen_rst_nxt;
      done_tick <= done_nxt;
      sq_d <= gen_rst ? 1'b0 : sq_wave_in;
      if (cfg_wr) tbl[cfg_addr] <= cfg_wdata;
    end
  end
endmodule

// File: tb/tb_sq_wave_pattern_sequencer.sv
// tb_sq_wave_pattern_sequencer: random and directed pattern runs against an event-level reference model
module tb_sq_wave_pattern_sequencer;
  localparam int AW = 2;
  localparam int T = 2;
  logic clk = 0, reset, cfg_wr, loop, start, stop, sq_wave_in;
  logic [AW-1:0] cfg_addr, last_idx, cur_idx;
  logic [15:0] cfg_wdata;
  logic [3:0] ctrl_on, ctrl_off;
  logic gen_rst, wave_en, busy, done_tick;
  int checks = 0, failures = 0, cyc = 0;

  sq_wave_pattern_sequencer dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .last_idx(last_idx), .loop(loop), .start(start), .stop(stop), .sq_wave_in(sq_wave_in),
    .ctrl_on(ctrl_on), .ctrl_off(ctrl_off), .gen_rst(gen_rst), .wave_en(wave_en),
    .busy(busy), .cur_idx(cur_idx), .done_tick(done_tick)
  );

  always #5 clk = ~clk;

  function automatic int mx1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic logic [15:0] ent(input int on, input int off, input int reps);
    return {8'(reps), 4'(off), 4'(on)};
  endfunction

  // reference model: tracks sequence position in terms of periods counted per entry
  int m_tbl [4];
  int m_run, m_idx, m_cnt, m_on, m_off, m_reps, m_prev, m_gr, m_done;
  logic [13:0] exp_q [$];

  task automatic mload(input int i);
    m_idx = i;
    m_cnt = 0;
    m_on = mx1(m_tbl[i] & 15);
    m_off = mx1((m_tbl[i] >> 4) & 15);
    m_reps = mx1(m_tbl[i] >> 8);
  endtask

  initial forever begin
    int rise, nd, ng, last;
    @(posedge clk);
    cyc++;
    rise = (sq_wave_in && !m_prev) ? 1 : 0;
    last = (int'(last_idx) > 3) ? 3 : int'(last_idx);
    if (reset) begin
      foreach (m_tbl[i]) m_tbl[i] = 'h0111;
      m_run = 0; m_idx = 0; m_cnt = 0; m_on = 1; m_off = 1; m_reps = 1;
      m_prev = 0; m_gr = 0; m_done = 0;
    end else begin
      nd = 0;
      ng = 0;
      if (m_run == 0) begin
        if (start && !stop) begin mload(0); m_run = 1; ng = 1; end
      end else if (stop) m_run = 0;
      else if (rise == 1) begin
        if (m_cnt + 1 < m_reps) m_cnt++;
        else if (m_idx != last) mload(m_idx + 1);
        else if (loop) mload(0);
        else begin m_run = 0; nd = 1; end
      end
      m_prev = m_gr ? 0 : int'(sq_wave_in);
      m_gr = ng;
      m_done = nd;
      if (cfg_wr) m_tbl[cfg_addr] = int'(cfg_wdata);
    end
    exp_q.push_back({4'(m_on), 4'(m_off), 1'(m_gr), 1'(m_run), 1'(m_run), 2'(m_idx), 1'(m_done)});
  end

  initial forever begin
    logic [13:0] e, a;
    @(negedge clk);
    a = {ctrl_on, ctrl_off, gen_rst, wave_en, busy, cur_idx, done_tick};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL outputs: cycle %0d no expectation queued, got %h", cyc, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        failures++;
        if (failures < 30)
          $display("FAIL outputs: cycle %0d got on=%0d off=%0d grst=%b wen=%b busy=%b idx=%0d done=%b, want on=%0d off=%0d grst=%b wen=%b busy=%b idx=%0d done=%b",
                   cyc, a[13:10], a[9:6], a[5], a[4], a[3], a[2:1], a[0], e[13:10], e[9:6], e[5], e[4], e[3], e[2:1], e[0]);
      end
    end
  end

  // behavioural generator: idles low, each period is OFF then ON, so a rise ends the OFF phase
  initial begin
    int gcnt, gph;
    sq_wave_in = 0;
    gcnt = 0;
    gph = 0;
    forever begin
      @(negedge clk);
      if (reset || gen_rst || !wave_en) begin
        gcnt = 0; gph = 0; sq_wave_in = 0;
      end else begin
        gcnt++;
        if (gph == 0 && gcnt >= T * mx1(int'(ctrl_off))) begin gph = 1; gcnt = 0; sq_wave_in = 1; end
        else if (gph == 1 && gcnt >= T * mx1(int'(ctrl_on))) begin gph = 0; gcnt = 0; sq_wave_in = 0; end
      end
    end
  end

  task automatic wr(input int a, input logic [15:0] d);
    cfg_wr = 1; cfg_addr = 2'(a); cfg_wdata = d;
    @(negedge clk);
    cfg_wr = 0;
  endtask

  task automatic go(input logic s, input logic p);
    start = s; stop = p;
    @(negedge clk);
    start = 0; stop = 0;
  endtask

  task automatic wait_cond(input int kind, input int maxc);
    int n;
    bit ok;
    n = 0;
    ok = 0;
    while (!ok && n < maxc) begin
      ok = (kind == 0 && !busy) || (kind == 1 && cur_idx == 2'd1) || (kind == 2 && busy && !sq_wave_in);
      if (!ok) begin @(negedge clk); n++; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait%0d: condition not reached in %0d cycles (required within %0d)", kind, n, maxc);
    end
  endtask

  initial begin
    int lim;
    reset = 1; cfg_wr = 0; cfg_addr = 0; cfg_wdata = 0; last_idx = 0; loop = 0; start = 0; stop = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    wr(0, ent(1, 3, 2));
    go(1, 0);
    wait_cond(0, 300);
    wr(0, ent(1, 3, 1));
    wr(1, ent(2, 2, 3));
    last_idx = 1;
    go(1, 0);
    wait_cond(0, 300);
    loop = 1;
    go(1, 0);
    repeat (90) @(negedge clk);
    wait_cond(2, 100);
    go(0, 1);
    repeat (3) @(negedge clk);
    go(1, 1);
    repeat (3) @(negedge clk);
    go(1, 0);
    repeat (10) @(negedge clk);
    go(1, 0);
    wr(1, ent(3, 1, 2));
    repeat (30) @(negedge clk);
    go(0, 1);
    loop = 0;
    last_idx = 0;
    wr(0, 16'h0000);
    go(1, 0);
    wait_cond(0, 200);
    wr(0, ent(1, 1, 1));
    last_idx = 1;
    go(1, 0);
    wait_cond(1, 200);
    reset = 1;
    @(negedge clk);
    reset = 0;
    last_idx = 3;
    go(1, 0);
    wait_cond(0, 300);
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 3)) wr($urandom_range(0, 3), ent($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)));
      last_idx = 2'($urandom);
      loop = 1'($urandom);
      go(1, $urandom_range(0, 7) == 0);
      lim = $urandom_range(50, 400);
      for (int c = 0; c < lim && busy; c++) begin
        cfg_wr = $urandom_range(0, 15) == 0;
        cfg_addr = 2'($urandom);
        cfg_wdata = ent($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        start = $urandom_range(0, 31) == 0;
        stop = $urandom_range(0, 199) == 0;
        reset = $urandom_range(0, 499) == 0;
        @(negedge clk);
      end
      cfg_wr = 0; start = 0; stop = 0; reset = 0;
      if (busy) go(0, 1);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
